// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor (a - b) with a start/done handshake.
// Optional signed-overflow output enabled by defining SUB_SIGNED_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SUB_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    // state | meaning
    // IDLE  | waiting for start, result registers hold last value
    // SHIFT | one result bit per edge, LSB first
    // DONE  | one-cycle result-valid pulse
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int CW = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sh_a, sh_b;
    logic [CW-1:0]    cnt;
    logic             br, br_nxt, d_bit, last;
`ifdef SUB_SIGNED_OVF_EN
    logic             a_msb, b_msb;
`endif

    always_comb begin
        d_bit     = sh_a[0] ^ sh_b[0] ^ br;
        br_nxt    = (~sh_a[0] & sh_b[0]) | (~(sh_a[0] ^ sh_b[0]) & br);
        last      = (cnt == CW'(WIDTH - 1));
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // diff doubles as the result shift register; it is complete after the last shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a   <= '0;
            sh_b   <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else if (state == IDLE && start) begin
            sh_a  <= a;
            sh_b  <= b;
            br    <= 1'b0;
            cnt   <= '0;
`ifdef SUB_SIGNED_OVF_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
        end else if (state == SHIFT) begin
            sh_a <= sh_a >> 1;
            sh_b <= sh_b >> 1;
            diff <= {d_bit, diff[WIDTH-1:1]};
            br   <= br_nxt;
            cnt  <= cnt + 1'b1;
            if (last) begin
                borrow <= br_nxt;
`ifdef SUB_SIGNED_OVF_EN
                // d_bit is the result MSB on the last shift
                ovf    <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
`endif
            end
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule
